// File: rtl/exception_controller_if.sv
// Signal bundle between exception_controller and the CPU control unit, IRQ sources and CP0.
// master: CPU/interrupt side that drives the requests; slave: the exception controller.
interface exception_controller_if #(
  parameter int unsigned N_IRQ = 4
);
  logic [N_IRQ-1:0] irq;
  logic [N_IRQ-1:0] irq_mask;
  logic             exc_ri;
  logic             exc_ovf;
  logic             exc_syscall;
  logic             eret;
  logic             inst_boundary;
  logic [31:0]      epc_i;
  logic             epc_write;
  logic             cause_write;
  logic [1:0]       int_cause;
  logic             pc_load;
  logic [31:0]      pc_target;
  logic [N_IRQ-1:0] irq_ack;
  logic             stall;
  logic             in_handler;
  logic             double_fault;

  modport master (
    output irq, irq_mask, exc_ri, exc_ovf, exc_syscall, eret, inst_boundary, epc_i,
    input  epc_write, cause_write, int_cause, pc_load, pc_target, irq_ack, stall,
           in_handler, double_fault
  );

  modport slave (
    input  irq, irq_mask, exc_ri, exc_ovf, exc_syscall, eret, inst_boundary, epc_i,
    output epc_write, cause_write, int_cause, pc_load, pc_target, irq_ack, stall,
           in_handler, double_fault
  );
endinterface

// File: rtl/exception_controller.sv
// CP0 exception/interrupt sequencer: arbitrates traps, strobes EPC/Cause, redirects the PC.
// Define EXC_IRQ_EDGE_EN for edge-triggered, latched IRQ pending bits (default: level-sensitive).
module exception_controller #(
  parameter int unsigned N_IRQ       = 4,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0180
) (
  input logic                  clk,
  input logic                  rst_n,
  exception_controller_if.slave bus
);
  localparam int unsigned IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_VECTOR,
    S_HANDLER,
    S_RETURN
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             is_irq_q, is_irq_d;
  logic             df_q, df_d;
  logic [31:0]      epc_q, epc_d;

  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] ack;
  logic [IW-1:0]    irq_idx;
  logic             sync_exc;
  logic [1:0]       sync_code;

  always_comb begin
    ack = '0;
    if (state_q == S_VECTOR && is_irq_q) begin
      for (int unsigned i = 0; i < N_IRQ; i++) begin
        ack[i] = (idx_q == IW'(i));
      end
    end
  end

`ifdef EXC_IRQ_EDGE_EN
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] pend_q, pend_d;

  // A new rising edge in the ack cycle must survive, so set is OR-ed after the clear.
  always_comb pend_d = (pend_q & ~ack) | (bus.irq & ~irq_q);
  always_comb pending = pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q  <= '0;
      pend_q <= '0;
    end else begin
      irq_q  <= bus.irq;
      pend_q <= pend_d;
    end
  end
`else
  always_comb pending = bus.irq;
`endif

  always_comb begin
    eligible  = pending & bus.irq_mask;
    sync_exc  = bus.exc_ri | bus.exc_ovf | bus.exc_syscall;
    sync_code = bus.exc_ri ? 2'd3 : (bus.exc_ovf ? 2'd2 : 2'd1);
    irq_idx   = '0;
    // Scan downwards so the lowest-numbered eligible line wins.
    for (int unsigned i = N_IRQ; i > 0; i--) begin
      if (eligible[i-1]) irq_idx = IW'(i - 1);
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    idx_d    = idx_q;
    is_irq_d = is_irq_q;
    df_d     = df_q;
    epc_d    = epc_q;
    unique case (state_q)
      S_IDLE: begin
        if (sync_exc) begin
          state_d  = S_SAVE;
          code_d   = sync_code;
          is_irq_d = 1'b0;
        end else if (bus.inst_boundary && (|eligible)) begin
          state_d  = S_SAVE;
          code_d   = 2'd0;
          is_irq_d = 1'b1;
          idx_d    = irq_idx;
        end
      end
      S_SAVE:   state_d = S_VECTOR;
      S_VECTOR: state_d = S_HANDLER;
      S_HANDLER: begin
        if (sync_exc) df_d = 1'b1;
        if (bus.eret) begin
          state_d = S_RETURN;
          epc_d   = bus.epc_i;
        end
      end
      S_RETURN: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      code_q   <= '0;
      idx_q    <= '0;
      is_irq_q <= 1'b0;
      df_q     <= 1'b0;
      epc_q    <= '0;
    end else begin
      state_q  <= state_d;
      code_q   <= code_d;
      idx_q    <= idx_d;
      is_irq_q <= is_irq_d;
      df_q     <= df_d;
      epc_q    <= epc_d;
    end
  end

  always_comb begin
    bus.epc_write    = (state_q == S_SAVE);
    bus.cause_write  = (state_q == S_SAVE);
    bus.int_cause    = code_q;
    bus.pc_load      = (state_q == S_VECTOR) || (state_q == S_RETURN);
    bus.pc_target    = '0;
    bus.irq_ack      = ack;
    bus.stall        = (state_q == S_SAVE) || (state_q == S_VECTOR) || (state_q == S_RETURN);
    bus.in_handler   = (state_q == S_HANDLER);
    bus.double_fault = df_q;
    if (state_q == S_VECTOR) bus.pc_target = TRAP_VECTOR;
    if (state_q == S_RETURN) bus.pc_target = epc_q;
  end
endmodule

// File: tb/tb_exception_controller.sv
// Self-checking bench for exception_controller: directed scenarios plus randomized traffic
// compared against a transaction-level reference model.
module tb_exception_controller;
  localparam int N = 4;

  typedef struct packed {
    logic        ew;
    logic        cw;
    logic [1:0]  ic;
    logic        pl;
    logic [31:0] pt;
    logic [N-1:0] ack;
    logic        st;
    logic        ih;
    logic        df;
  } out_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_bad = 0;

  exception_controller_if #(.N_IRQ(N)) b ();
  exception_controller #(.N_IRQ(N), .TRAP_VECTOR(32'h0000_0180)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of upcoming fixed-length phases (1=save, 2=vector, 3=return)
  // plus handler/fault/cause flags.
  int           fq[$];
  bit           m_h, m_df;
  logic [1:0]   m_cause;
  logic [N-1:0] m_ack, m_pend, m_prev;
  logic [31:0]  m_epc;

  function automatic out_t dut_out();
    out_t o;
    o = '{b.epc_write, b.cause_write, b.int_cause, b.pc_load, b.pc_target,
          b.irq_ack, b.stall, b.in_handler, b.double_fault};
    return o;
  endfunction

  function automatic out_t exp_out();
    out_t o;
    o = '0;
    o.ic = m_cause;
    o.df = m_df;
    if (fq.size() == 0) o.ih = m_h;
    else if (fq[0] == 1) begin o.ew = 1; o.cw = 1; o.st = 1; end
    else if (fq[0] == 2) begin o.pl = 1; o.pt = 32'h180; o.ack = m_ack; o.st = 1; end
    else begin o.pl = 1; o.pt = m_epc; o.st = 1; end
    return o;
  endfunction

  task automatic model_reset();
    fq.delete();
    m_h = 0; m_df = 0; m_cause = '0; m_ack = '0; m_pend = '0; m_prev = '0; m_epc = '0;
  endtask

  task automatic model_edge();
    int cur;
    logic [N-1:0] pend_eff, elig;
    logic sync;
    cur = (fq.size() != 0) ? fq[0] : 0;
`ifdef EXC_IRQ_EDGE_EN
    pend_eff = m_pend;
`else
    pend_eff = b.irq;
`endif
    elig = pend_eff & b.irq_mask;
    sync = b.exc_ri | b.exc_ovf | b.exc_syscall;
    if (cur != 0) begin
      void'(fq.pop_front());
      if (cur == 2) m_h = 1;
    end else if (m_h) begin
      if (sync) m_df = 1;
      if (b.eret) begin m_h = 0; m_epc = b.epc_i; fq.push_back(3); end
    end else if (sync || (b.inst_boundary && elig != '0)) begin
      m_ack = '0;
      if (b.exc_ri) m_cause = 2'd3;
      else if (b.exc_ovf) m_cause = 2'd2;
      else if (b.exc_syscall) m_cause = 2'd1;
      else begin m_cause = 2'd0; m_ack = elig & (~elig + N'(1)); end
      fq.push_back(1);
      fq.push_back(2);
    end
    m_pend = (m_pend & ~((cur == 2) ? m_ack : '0)) | (b.irq & ~m_prev);
    m_prev = b.irq;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    b.exc_ri = 0; b.exc_ovf = 0; b.exc_syscall = 0; b.eret = 0;
  endtask

  task automatic do_reset();
    b.irq = '0; b.irq_mask = '1; b.exc_ri = 0; b.exc_ovf = 0; b.exc_syscall = 0;
    b.eret = 0; b.inst_boundary = 0; b.epc_i = '0;
    rst_n = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (dut_out() !== out_t'(0)) begin n_bad++; $display("FAIL reset_outputs got=%h exp=0", dut_out()); end
    tick();
    n_cmp++; if (dut_out() !== out_t'(0)) begin n_bad++; $display("FAIL idle_outputs got=%h exp=0", dut_out()); end
  endtask

  task automatic test_ovf();
    do_reset();
    b.exc_ovf = 1; tick();
    n_cmp++; if ({b.epc_write, b.cause_write, b.int_cause, b.stall, b.pc_load} !== 6'b11_10_1_0) begin
      n_bad++; $display("FAIL ovf_save got=%b exp=111010", {b.epc_write, b.cause_write, b.int_cause, b.stall, b.pc_load}); end
    tick();
    n_cmp++; if ({b.pc_load, b.pc_target, b.epc_write, b.irq_ack} !== {1'b1, 32'h180, 1'b0, 4'b0}) begin
      n_bad++; $display("FAIL ovf_vector got pl=%b pt=%h exp pl=1 pt=00000180", b.pc_load, b.pc_target); end
    tick();
    n_cmp++; if ({b.in_handler, b.stall, b.int_cause} !== 4'b1_0_10) begin
      n_bad++; $display("FAIL ovf_handler got=%b exp=1010", {b.in_handler, b.stall, b.int_cause}); end
    b.epc_i = 32'h0040_0100; b.eret = 1; tick();
    n_cmp++; if ({b.pc_load, b.pc_target, b.in_handler} !== {1'b1, 32'h0040_0100, 1'b0}) begin
      n_bad++; $display("FAIL ovf_return got pl=%b pt=%h exp pl=1 pt=00400100", b.pc_load, b.pc_target); end
    tick();
    n_cmp++; if ({b.pc_load, b.pc_target, b.stall, b.in_handler} !== 35'b0) begin
      n_bad++; $display("FAIL ovf_back_idle got pl=%b pt=%h st=%b", b.pc_load, b.pc_target, b.stall); end
  endtask

  task automatic test_ri_syscall();
    do_reset();
    b.exc_ri = 1; b.exc_syscall = 1; tick();
    n_cmp++; if (b.int_cause !== 2'd3) begin n_bad++; $display("FAIL ri_priority got=%0d exp=3", b.int_cause); end
    tick(); tick();
    b.eret = 1; tick(); tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({b.epc_write, b.in_handler} !== 2'b00) begin
        n_bad++; $display("FAIL syscall_not_stored got=%b exp=00", {b.epc_write, b.in_handler}); end
      tick();
    end
  endtask

  task automatic test_irq_priority();
    do_reset();
    b.irq = 4'b0110; tick();
    b.inst_boundary = 1; tick();
    n_cmp++; if ({b.epc_write, b.int_cause} !== 3'b1_00) begin
      n_bad++; $display("FAIL irq_save got=%b exp=100", {b.epc_write, b.int_cause}); end
    tick();
    n_cmp++; if (b.irq_ack !== 4'b0010) begin n_bad++; $display("FAIL irq_ack got=%b exp=0010", b.irq_ack); end
    b.irq = 4'b0100; tick();
    n_cmp++; if (b.in_handler !== 1'b1) begin n_bad++; $display("FAIL irq_handler got=%b exp=1", b.in_handler); end
    tick();
    n_cmp++; if (b.epc_write !== 1'b0) begin n_bad++; $display("FAIL irq_masked_in_handler got=%b exp=0", b.epc_write); end
    b.epc_i = 32'h0040_0020; b.eret = 1; tick();
    n_cmp++; if (b.pc_target !== 32'h0040_0020) begin n_bad++; $display("FAIL irq_return_pc got=%h exp=00400020", b.pc_target); end
    tick(); tick();
    n_cmp++; if ({b.epc_write, b.int_cause} !== 3'b1_00) begin
      n_bad++; $display("FAIL irq2_save got=%b exp=100", {b.epc_write, b.int_cause}); end
    tick();
    n_cmp++; if (b.irq_ack !== 4'b0100) begin n_bad++; $display("FAIL irq2_ack got=%b exp=0100", b.irq_ack); end
  endtask

  task automatic test_boundary();
    do_reset();
    b.irq = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if ({b.epc_write, b.cause_write, b.pc_load} !== 3'b000) begin
        n_bad++; $display("FAIL no_boundary got=%b exp=000", {b.epc_write, b.cause_write, b.pc_load}); end
    end
    b.inst_boundary = 1; tick();
    n_cmp++; if (b.epc_write !== 1'b1) begin n_bad++; $display("FAIL boundary_save got=%b exp=1", b.epc_write); end
    tick();
    n_cmp++; if (b.irq_ack !== 4'b0001) begin n_bad++; $display("FAIL boundary_ack got=%b exp=0001", b.irq_ack); end
  endtask

  task automatic test_double_fault();
    do_reset();
    b.exc_ovf = 1; tick(); tick(); tick();
    b.exc_syscall = 1; tick();
    n_cmp++; if ({b.double_fault, b.epc_write, b.in_handler} !== 3'b101) begin
      n_bad++; $display("FAIL df_set got=%b exp=101", {b.double_fault, b.epc_write, b.in_handler}); end
    tick(); tick();
    n_cmp++; if ({b.in_handler, b.int_cause} !== 3'b1_10) begin
      n_bad++; $display("FAIL df_stay_handler got=%b exp=110", {b.in_handler, b.int_cause}); end
    b.eret = 1; b.exc_ri = 1; b.epc_i = 32'h1234; tick();
    n_cmp++; if ({b.pc_load, b.pc_target, b.double_fault} !== {1'b1, 32'h1234, 1'b1}) begin
      n_bad++; $display("FAIL df_eret_wins got pl=%b pt=%h df=%b exp 1 00001234 1", b.pc_load, b.pc_target, b.double_fault); end
    tick();
    n_cmp++; if ({b.in_handler, b.double_fault, b.epc_write} !== 3'b010) begin
      n_bad++; $display("FAIL df_sticky got=%b exp=010", {b.in_handler, b.double_fault, b.epc_write}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    b.exc_ovf = 1; tick(); tick();
    n_cmp++; if (b.pc_load !== 1'b1) begin n_bad++; $display("FAIL mid_in_vector got=%b exp=1", b.pc_load); end
    rst_n = 0; model_reset(); #1;
    n_cmp++; if (dut_out() !== out_t'(0)) begin n_bad++; $display("FAIL mid_reset_outputs got=%h exp=0", dut_out()); end
    @(posedge clk); #1; rst_n = 1; tick();
    n_cmp++; if (dut_out() !== out_t'(0)) begin n_bad++; $display("FAIL mid_no_strobes got=%h exp=0", dut_out()); end
`ifdef EXC_IRQ_EDGE_EN
    b.irq_mask = 4'b1101; b.inst_boundary = 1; b.irq = 4'b0010; tick();
    b.irq = 4'b0000; tick(); tick();
    n_cmp++; if (b.epc_write !== 1'b0) begin n_bad++; $display("FAIL glitch_masked got=%b exp=0", b.epc_write); end
    b.irq_mask = 4'b1111; tick();
    n_cmp++; if ({b.epc_write, b.int_cause} !== 3'b1_00) begin
      n_bad++; $display("FAIL glitch_taken got=%b exp=100", {b.epc_write, b.int_cause}); end
    tick();
    n_cmp++; if (b.irq_ack !== 4'b0010) begin n_bad++; $display("FAIL glitch_ack got=%b exp=0010", b.irq_ack); end
`endif
  endtask

  task automatic test_random();
    out_t e;
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(0, 9) == 0) b.irq[k] = ~b.irq[k];
      if ($urandom_range(0, 19) == 0) b.irq_mask = N'($urandom);
      b.inst_boundary = ($urandom_range(0, 9) < 7);
      b.exc_ri      = ($urandom_range(0, 24) == 0);
      b.exc_ovf     = ($urandom_range(0, 19) == 0);
      b.exc_syscall = ($urandom_range(0, 14) == 0);
      b.eret        = ($urandom_range(0, 5) == 0);
      b.epc_i       = $urandom;
      if ($urandom_range(0, 299) == 0) begin do_reset(); end
      tick();
      e = exp_out();
      n_cmp++; if (dut_out() !== e) begin
        n_bad++; $display("FAIL random_cycle%0d got=%h exp=%h", c, dut_out(), e); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ovf();
    test_ri_syscall();
    test_irq_priority();
    test_boundary();
    test_double_fault();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/exception_controller.md
# exception_controller

Sequencer for the CP0 register block: arbitrates synchronous exceptions and external interrupt requests and drives the CP0 EPC/Cause write strobes and 2-bit cause code. Redirects the CPU PC to the trap vector, and back to EPC on `eret`. Sits between the CPU control unit, the interrupt sources and the coprocessor. Stalls the pipeline while it sequences.

## Interface
- `N_IRQ`, default 4: number of external interrupt lines, 1..8.
- `TRAP_VECTOR`, default 32'h0000_0180: handler entry address.

- `clk`, in, 1: system clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `irq`, in, N_IRQ: external interrupt requests. Index 0 has the highest priority.
- `irq_mask`, in, N_IRQ: 1 enables the matching line.
- `exc_ri`, in, 1: reserved instruction. Single-cycle pulse.
- `exc_ovf`, in, 1: arithmetic overflow. Single-cycle pulse.
- `exc_syscall`, in, 1: syscall. Single-cycle pulse.
- `eret`, in, 1: return from handler. Single-cycle pulse.
- `inst_boundary`, in, 1: CPU is between instructions, so an interrupt may be taken.
- `epc_i`, in, 32: EPC value read back from CP0.
- `epc_write`, out, 1: connects to CP0 EPCWrite. CP0 captures the current PC.
- `cause_write`, out, 1: connects to CP0 CauseWrite.
- `int_cause`, out, 2: connects to CP0 IntCause.
- `pc_load`, out, 1: CPU loads `pc_target` into the PC.
- `pc_target`, out, 32: redirect address.
- `irq_ack`, out, N_IRQ: one-hot acknowledge pulse.
- `stall`, out, 1: freezes the CPU PC and pipeline.
- `in_handler`, out, 1: a handler is executing.
- `double_fault`, out, 1: sticky error flag.

## Operation
Cause codes:
- 0 = interrupt
- 1 = syscall
- 2 = overflow
- 3 = reserved instruction

Priority, highest first: `exc_ri`, `exc_ovf`, `exc_syscall`, then `irq[0]` through `irq[N_IRQ-1]`.

A line is eligible when `pending[i] & irq_mask[i]`.

States:
- **IDLE**
  - A synchronous exception goes to SAVE, regardless of `inst_boundary`.
  - Otherwise, any eligible IRQ with `inst_boundary`=1 goes to SAVE.
  - The winner's code and IRQ index are registered on entry.
  - `eret` in IDLE is ignored.
- **SAVE**, 1 cycle: `epc_write`=1, `cause_write`=1, `int_cause`=registered code, `stall`=1. Next state is VECTOR.
- **VECTOR**, 1 cycle:
  - `pc_load`=1, `pc_target`=TRAP_VECTOR, `stall`=1.
  - `irq_ack[idx]`=1 only if the winner was an IRQ.
  - Next state is HANDLER.
- **HANDLER**
  - `in_handler`=1. IRQs are not taken.
  - `eret` goes to RETURN.
  - A synchronous exception sets `double_fault`, is otherwise dropped, and the state is unchanged.
- **RETURN**, 1 cycle: `pc_load`=1, `pc_target`=`epc_i`, `stall`=1. Next state is IDLE.

General rules:
- Outputs not listed as asserted in a state are 0.
- `int_cause` holds its last value outside SAVE.
- `pc_target` is 0 outside VECTOR and RETURN.
- `double_fault` clears only on reset.
- Simultaneous sync exception and eligible IRQ: the exception wins. The IRQ stays pending and is taken after the handler returns.
- Simultaneous `eret` and sync exception in HANDLER: `eret` is taken, and `double_fault` is also set.

## Timing
- Sync exception pulse sampled at edge T:
  - SAVE outputs during T..T+1.
  - VECTOR (`pc_load`) during T+1..T+2.
  - `in_handler` from T+2.
- IRQ: same latency, measured from the first edge where it is eligible and `inst_boundary`=1.
- `eret` at edge T: `pc_load` with EPC during T..T+1, then IDLE.
- All outputs are Moore-decoded from registered state. There are no combinational input-to-output paths.
- Reset (`rst_n`=0, any time):
  - State goes to IDLE and `pending` to 0.
  - All outputs go to 0, including `int_cause` and `double_fault`.
  - Reset mid-SAVE/VECTOR/RETURN aborts the sequence. No strobes follow.

## Configuration
- `EXC_IRQ_EDGE_EN` defined:
  - `pending[i]` is set on a rising edge of `irq[i]`, detected via a registered copy of `irq`.
  - `pending[i]` is cleared by `irq_ack[i]`. If an edge arrives in the same cycle as the ack, set wins.
  - Masking does not clear `pending`.
- Undefined:
  - Level-sensitive: `pending` = `irq`, with no storage.
  - The source must hold the line until acked. A line still high after `eret` retriggers.

## Test plan
- Reset, then `exc_ovf` pulse → `epc_write`=`cause_write`=1 with `int_cause`=2 for one cycle. Next cycle `pc_load`=1 with `pc_target`=32'h180, then `in_handler`=1.
- `exc_ri` and `exc_syscall` in the same cycle → `int_cause`=3. After `eret`, the pending syscall is not re-taken, because sync pulses are not stored.
- `irq`=4'b0110, `irq_mask`=4'b1111, `inst_boundary`=1 → `int_cause`=0 and `irq_ack`=4'b0010. After `eret` with `epc_i`=32'h0040_0020: `pc_target`=32'h0040_0020, then `irq[2]` is taken.
- `irq[0]` high with `inst_boundary`=0 for 5 cycles → no strobes. `inst_boundary`=1 → SAVE the next cycle.
- `exc_syscall` inside HANDLER → `double_fault`=1, no `epc_write`, and the state stays HANDLER until `eret`.
- `rst_n` low during VECTOR → all outputs 0. With `EXC_IRQ_EDGE_EN`, a 1-cycle `irq[1]` glitch while masked is taken once it is unmasked.
